// File: rtl/la_pkg.sv
// Shared logic-analyser definitions: capture FSM state type and default sample-RAM geometry.
package la_pkg;

    localparam int LA_ENTRIES = 384;
    localparam int LA_ADDR_W  = 9;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_FILL = 2'd1,
        CAP_POST = 2'd2,
        CAP_DONE = 2'd3
    } cap_state_t;

endpackage

// File: rtl/wrap_cntr.sv
// Modulo-MOD up-counter with synchronous clear and count enable; wraps MOD-1 -> 0.
module wrap_cntr #(
    parameter int MOD = 384,
    parameter int W   = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/capture_ctrl.sv
// Logic-analyser capture controller: ring-buffer fill, trigger arm, post-trigger count, dump pointer.
// Optional build macro CAPTURE_FORCE_TRIG_EN adds a force_trig input that triggers FILL unconditionally.
module capture_ctrl
    import la_pkg::*;
#(
    parameter int ENTRIES = LA_ENTRIES,
    parameter int ADDR_W  = LA_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              wrt_smpl,
    input  logic              triggered,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              clr_done,
`ifdef CAPTURE_FORCE_TRIG_EN
    input  logic              force_trig,
`endif
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              armed,
    output logic              capture_done,
    output logic [ADDR_W-1:0] oldest_addr,
    output cap_state_t        o_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);

    cap_state_t        r_state;
    cap_state_t        w_next;
    logic              r_armed;
    logic              r_done;
    logic [ADDR_W-1:0] r_oldest;

    logic [ADDR_W-1:0] w_teff;
    logic [ADDR_W-1:0] w_arm_idx;
    logic              w_teff_zero;
    logic [ADDR_W-1:0] w_waddr;
    logic [ADDR_W-1:0] w_waddr_inc;
    logic [ADDR_W-1:0] w_pre_cnt;
    logic [ADDR_W-1:0] w_post_cnt;
    logic              w_pre_last;
    logic              w_post_last;
    logic              w_trig_hit;

    logic              w_we;
    logic              w_pre_clr;
    logic              w_pre_en;
    logic              w_post_clr;
    logic              w_post_en;
    logic              w_start;
    logic              w_abort;
    logic              w_release;
    logic              w_finish;

    // Post-trigger depth is clamped so at least one pre-trigger sample always survives.
    assign w_teff      = ({1'b0, trig_pos} < (ADDR_W + 1)'(ENTRIES)) ? trig_pos : LAST_ADDR;
    assign w_teff_zero = (w_teff == '0);
    assign w_arm_idx   = LAST_ADDR - w_teff;
    assign w_pre_last  = (w_pre_cnt == w_arm_idx);
    assign w_post_last = (w_post_cnt == w_teff - ADDR_W'(1));
    assign w_waddr_inc = (w_waddr == LAST_ADDR) ? '0 : w_waddr + ADDR_W'(1);

`ifdef CAPTURE_FORCE_TRIG_EN
    assign w_trig_hit = (r_armed & triggered) | force_trig;
`else
    assign w_trig_hit = r_armed & triggered;
`endif

    wrap_cntr #(.MOD(ENTRIES), .W(ADDR_W)) u_waddr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_en  (w_we),
        .o_cnt (w_waddr)
    );

    wrap_cntr #(.MOD(ENTRIES), .W(ADDR_W)) u_pre_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_pre_clr),
        .i_en  (w_pre_en),
        .o_cnt (w_pre_cnt)
    );

    wrap_cntr #(.MOD(ENTRIES), .W(ADDR_W)) u_post_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_post_clr),
        .i_en  (w_post_en),
        .o_cnt (w_post_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CAP_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Dropping run abandons a capture from either active state; it has priority over trigger/finish.
    always_comb begin
        w_next = r_state;
        case (r_state)
            CAP_IDLE: begin
                if (run) w_next = CAP_FILL;
            end
            CAP_FILL: begin
                if (!run)            w_next = CAP_IDLE;
                else if (w_trig_hit) w_next = CAP_POST;
            end
            CAP_POST: begin
                if (!run)                              w_next = CAP_IDLE;
                else if (w_teff_zero)                  w_next = CAP_DONE;
                else if (w_we && w_post_last)          w_next = CAP_DONE;
            end
            CAP_DONE: begin
                if (clr_done) w_next = CAP_IDLE;
            end
            default: w_next = CAP_IDLE;
        endcase
    end

    // A zero-length post window writes nothing while passing through POST.
    always_comb begin
        w_we       = 1'b0;
        w_pre_clr  = 1'b0;
        w_pre_en   = 1'b0;
        w_post_clr = 1'b0;
        w_post_en  = 1'b0;
        w_start    = 1'b0;
        w_abort    = 1'b0;
        w_release  = 1'b0;
        w_finish   = 1'b0;
        if (!rst) begin
            w_we = wrt_smpl & ((r_state == CAP_FILL) |
                               ((r_state == CAP_POST) & ~w_teff_zero));
        end
        w_start    = (r_state == CAP_IDLE) & run;
        w_abort    = ((r_state == CAP_FILL) | (r_state == CAP_POST)) & ~run;
        w_release  = (r_state == CAP_DONE) & clr_done;
        w_finish   = (r_state == CAP_POST) & (w_next == CAP_DONE);
        w_pre_clr  = w_start;
        w_pre_en   = w_we & (r_state == CAP_FILL);
        w_post_clr = (r_state == CAP_FILL) & (w_next == CAP_POST);
        w_post_en  = w_we & (r_state == CAP_POST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed  <= 1'b0;
            r_done   <= 1'b0;
            r_oldest <= '0;
        end else begin
            if (w_start || w_abort || w_release) begin
                r_armed <= 1'b0;
            end else if (w_pre_en && w_pre_last) begin
                r_armed <= 1'b1;
            end
            // The oldest sample sits just past the final write (or at waddr if nothing was written).
            if (w_finish) begin
                r_done   <= 1'b1;
                r_oldest <= w_we ? w_waddr_inc : w_waddr;
            end else if (w_release) begin
                r_done <= 1'b0;
            end
        end
    end

    assign we           = w_we;
    assign waddr        = w_waddr;
    assign armed        = r_armed;
    assign capture_done = r_done;
    assign oldest_addr  = r_oldest;
    assign o_state      = r_state;

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 384, sample-RAM depth in samples.
REQ-002 SHALL have parameter ADDR_W, default 9, RAM address width; ENTRIES <= 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  system clock, 100MHz.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port run  input  1  capture enable, the run bit of trig_cfg.
REQ-006 SHALL have port wrt_smpl  input  1  one-cycle strobe, decimated sample valid.
REQ-007 SHALL have port triggered  input  1  trigger-logic hit, level.
REQ-008 SHALL have port trig_pos  input  ADDR_W  number of post-trigger samples.
REQ-009 SHALL have port clr_done  input  1  host clears capture_done.
REQ-010 SHALL have port we  output  1  sample-RAM write enable, all channel RAMs.
REQ-011 SHALL have port waddr  output  ADDR_W  sample-RAM write address.
REQ-012 SHALL have port armed  output  1  enough pre-trigger samples held; gates trigger logic.
REQ-013 SHALL have port capture_done  output  1  capture complete; drives status bit and LED.
REQ-014 SHALL have port oldest_addr  output  ADDR_W  start address for channel dump.

Function
REQ-015 SHALL implement states IDLE, FILL, POST, DONE.
REQ-016 SHALL go IDLE->FILL when run=1; pre-sample count clears to 0 on entry.
REQ-017 SHALL drive we = wrt_smpl & (state==FILL | state==POST), combinationally, same cycle as the strobe.
REQ-018 SHALL advance waddr by 1 on every cycle with we=1, wrapping ENTRIES-1 -> 0; waddr is never reset on a new run.
REQ-019 SHALL assert armed (registered) once the FILL write count reaches ENTRIES - trig_eff.
REQ-020 SHALL define trig_eff = trig_pos if trig_pos < ENTRIES, else ENTRIES-1.
REQ-021 SHALL go FILL->POST on the first cycle with armed=1 & triggered=1; the post-sample counter loads 0.
REQ-022 SHALL count a sample written in the same cycle as the trigger as pre-trigger.
REQ-023 SHALL ignore triggered while armed=0.
REQ-024 SHALL go POST->DONE on the write that makes the post count equal trig_eff; with trig_eff=0, SHALL go POST->DONE one cycle after entry, with no POST write.
REQ-025 SHALL assert capture_done in DONE and latch oldest_addr = waddr after the final write.
REQ-026 SHALL produce no writes in DONE; clr_done in DONE SHALL return to IDLE and clear capture_done and armed.
REQ-027 SHALL return to IDLE from FILL or POST when run=0, leaving capture_done and oldest_addr unchanged.
REQ-028 SHALL ignore clr_done outside DONE.

Reset
REQ-029 SHALL, while rst=1, force state IDLE, waddr 0, oldest_addr 0, armed 0, capture_done 0, both counters 0; we SHALL be 0.
REQ-030 SHALL abandon any capture in progress on rst mid-capture, with no further writes.

Configuration
REQ-031 SHALL add input force_trig (1 bit) with macro CAPTURE_FORCE_TRIG_EN defined; it is treated as triggered=1 in FILL regardless of armed.
REQ-032 SHALL omit the port without CAPTURE_FORCE_TRIG_EN and behave per REQ-021/023.

Structure
REQ-033 SHALL import cap_state_t (state enum) and LA_ENTRIES=384 from shared package la_pkg.
REQ-034 SHALL use one sub-module, wrap_cntr (parameterised modulo-ENTRIES counter with enable and clear), instanced for waddr and the sample counts.

Verification
REQ-035 SHALL cover: rst, run=1, trig_pos=16, wrt_smpl every 4 clk, triggered at write 400 -> armed after write 368; 16 POST writes at addrs 16..31; capture_done=1; oldest_addr=32.
REQ-036 SHALL cover: trig_pos=0, trigger after armed -> DONE one cycle after POST entry, zero POST writes, oldest_addr=waddr at trigger.
REQ-037 SHALL cover: triggered=1 from cycle 0, trig_pos=100 -> no POST entry until write 284, then exactly 100 more writes.
REQ-038 SHALL cover: run dropped in POST after 5 writes -> IDLE, we=0, capture_done stays 0; next run resumes from the current waddr.
REQ-039 SHALL cover: DONE, then clr_done pulse -> capture_done=0, state IDLE next cycle; wrt_smpl strobes in DONE produce we=0.
REQ-040 SHALL cover: CAPTURE_FORCE_TRIG_EN build, force_trig at write 10 with trig_pos=16 -> POST entered at write 10, 16 writes, done.
